// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the load/store sequencer.
package mem_pkg;

    localparam int unsigned DEFAULT_DEPTH = 1024;
    localparam int unsigned DEFAULT_AW    = 24;
    localparam int unsigned WORD_BYTES    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one word request in, one memory strobe, one response out.
// Out-of-range requests are answered with an error and never touch the memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [AW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_address,
    output logic [AW-1:0] mem_in_data,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [AW-1:0] mem_out_data
);

    // Highest byte address at which a full word still fits inside the memory
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - WORD_BYTES);

    state_e        state_q, state_d;
    logic          wr_q, wr_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [AW-1:0] resp_rdata_q, resp_rdata_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [AW-1:0] mem_in_data_q, mem_in_data_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic          in_range_c;

    assign in_range_c = (req_addr <= LAST_ADDR);

    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        resp_valid_d  = resp_valid_q;
        resp_err_d    = resp_err_q;
        resp_rdata_d  = resp_rdata_q;
        mem_address_d = mem_address_q;
        mem_in_data_d = mem_in_data_q;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d = req_wr;
                    if (in_range_c) begin
                        state_d       = ISSUE;
                        mem_address_d = req_addr;
                        mem_in_data_d = req_wdata;
                        mem_rd_d      = ~req_wr;
                        mem_wr_d      = req_wr;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                // Memory acts on this edge; stores have nothing to wait for
                if (wr_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = mem_out_data;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_q          <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_address_q <= '0;
            mem_in_data_q <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
            mem_address_q <= mem_address_d;
            mem_in_data_q <= mem_in_data_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_in_data = mem_in_data_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a byte-addressed big-endian data memory and a
// word-level reference model of expected responses and latencies.
module tb_mem_access_unit;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [23:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [23:0] resp_rdata;
    logic [23:0] mem_address, mem_in_data, mem_out_data;
    logic        mem_rd, mem_wr;
    logic        mem_rst_n;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_in_data(mem_in_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_out_data(mem_out_data)
    );

    // Data memory: registered read, big-endian words, active-low reset
    assign mem_rst_n = ~reset;
    logic [7:0] mem_bytes [DEPTH];
    bit         mem_loaded = 1'b0;

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    always @(posedge clk) begin
        int a;
        a = int'(mem_address);
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) mem_bytes[i] <= init_byte(i);
            mem_loaded <= 1'b1;
        end else if (mem_wr && a + 2 < DEPTH) begin
            mem_bytes[a]     <= mem_in_data[23:16];
            mem_bytes[a + 1] <= mem_in_data[15:8];
            mem_bytes[a + 2] <= mem_in_data[7:0];
        end
        if (!mem_rst_n)
            mem_out_data <= '0;
        else if (mem_rd && a + 2 < DEPTH)
            mem_out_data <= {mem_bytes[a], mem_bytes[a + 1], mem_bytes[a + 2]};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // Reference model at word level
    function automatic bit model_in_range(logic [23:0] a);
        return int'(a) <= DEPTH - 3;
    endfunction

    function automatic logic [23:0] model_rdata(logic wr, logic [23:0] a);
        int i;
        i = int'(a);
        if (wr || !model_in_range(a)) return 24'h0;
        return {ref_mem[i], ref_mem[i + 1], ref_mem[i + 2]};
    endfunction

    function automatic int model_lat(logic wr, logic [23:0] a);
        if (!model_in_range(a)) return 1;
        return wr ? 2 : 3;
    endfunction

    function automatic void model_apply(logic wr, logic [23:0] a, logic [23:0] d);
        int i;
        i = int'(a);
        if (wr && model_in_range(a)) begin
            ref_mem[i]     = d[23:16];
            ref_mem[i + 1] = d[15:8];
            ref_mem[i + 2] = d[7:0];
        end
    endfunction

    // Drives one request and reports what was observed; callers judge it
    task automatic txn(input logic wr, input logic [23:0] addr, input logic [23:0] wdata,
                       input int stall, output int lat, output logic [23:0] rdata,
                       output logic err, output int rd_cnt, output int wr_cnt,
                       output bit strobe_bad, output bit stall_bad, output bit idle_ok);
        int guard;
        lat = -1; rdata = '0; err = 1'b0; rd_cnt = 0; wr_cnt = 0;
        strobe_bad = 0; stall_bad = 0; idle_ok = 0; guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        resp_ready = (stall == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_wr = 1'($urandom); req_addr = 24'($urandom); req_wdata = 24'($urandom);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                rd_cnt++;
                if (mem_address !== addr) strobe_bad = 1;
            end
            if (mem_wr === 1'b1) begin
                wr_cnt++;
                if (mem_address !== addr || mem_in_data !== wdata) strobe_bad = 1;
            end
            if (resp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            resp_ready = 1'b1;
            return;
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err ||
                req_ready !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0)
                stall_bad = 1;
            if (s == stall - 1) resp_ready = 1'b1;
        end
        @(negedge clk);
        idle_ok = (req_ready === 1'b1 && resp_valid === 1'b0 && resp_err === 1'b0 &&
                   mem_rd === 1'b0 && mem_wr === 1'b0 && resp_rdata === rdata);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        tests_run++;
        if ({resp_valid, resp_err, mem_rd, mem_wr} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=0000", {resp_valid, resp_err, mem_rd, mem_wr});
        end
        tests_run++;
        if ({resp_rdata, mem_address, mem_in_data} !== 72'h0) begin
            tests_failed++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", resp_rdata, mem_address, mem_in_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        int lat, rc, wc; logic [23:0] rd; logic er; bit sb, stb, ok;
        txn(1'b1, 24'h10, 24'hABCDEF, 0, lat, rd, er, rc, wc, sb, stb, ok);
        model_apply(1'b1, 24'h10, 24'hABCDEF);
        tests_run++;
        if (wc !== 1 || rc !== 0 || sb !== 0) begin
            tests_failed++; $display("FAIL store_strobe wr=%0d rd=%0d bad=%0d exp wr=1 rd=0 bad=0", wc, rc, sb);
        end
        tests_run++;
        if (lat !== 2 || rd !== 24'h0 || er !== 1'b0 || ok !== 1) begin
            tests_failed++; $display("FAIL store_resp lat=%0d rdata=%h err=%b idle=%0d exp 2/0/0/1", lat, rd, er, ok);
        end
        txn(1'b0, 24'h10, 24'h0, 0, lat, rd, er, rc, wc, sb, stb, ok);
        tests_run++;
        if (lat !== 3 || rd !== 24'hABCDEF || er !== 1'b0) begin
            tests_failed++; $display("FAIL load_back lat=%0d rdata=%h err=%b exp 3/abcdef/0", lat, rd, er);
        end
        tests_run++;
        if (rc !== 1 || wc !== 0 || sb !== 0 || ok !== 1) begin
            tests_failed++; $display("FAIL load_strobe rd=%0d wr=%0d bad=%0d idle=%0d exp 1/0/0/1", rc, wc, sb, ok);
        end
    endtask

    task automatic test_byte_order();
        int lat, rc, wc; logic [23:0] rd, exp_rd; logic er; bit sb, stb, ok;
        txn(1'b1, 24'd5, 24'h123456, 0, lat, rd, er, rc, wc, sb, stb, ok);
        model_apply(1'b1, 24'd5, 24'h123456);
        exp_rd = {8'h34, 8'h56, ref_mem[8]};
        txn(1'b0, 24'd6, 24'h0, 0, lat, rd, er, rc, wc, sb, stb, ok);
        tests_run++;
        if (rd !== exp_rd || lat !== 3) begin
            tests_failed++; $display("FAIL byte_order rdata=%h lat=%0d exp %h/3", rd, lat, exp_rd);
        end
    endtask

    task automatic test_range();
        int lat, rc, wc; logic [23:0] rd, exp_rd; logic er; bit sb, stb, ok;
        txn(1'b0, 24'd1022, 24'h0, 0, lat, rd, er, rc, wc, sb, stb, ok);
        tests_run++;
        if (er !== 1'b1 || rd !== 24'h0 || lat !== 1 || rc !== 0 || wc !== 0 || ok !== 1) begin
            tests_failed++;
            $display("FAIL range_1022 err=%b rdata=%h lat=%0d rd=%0d wr=%0d idle=%0d exp 1/0/1/0/0/1", er, rd, lat, rc, wc, ok);
        end
        exp_rd = model_rdata(1'b0, 24'd1021);
        txn(1'b0, 24'd1021, 24'h0, 0, lat, rd, er, rc, wc, sb, stb, ok);
        tests_run++;
        if (er !== 1'b0 || rd !== exp_rd || lat !== 3 || rc !== 1) begin
            tests_failed++; $display("FAIL range_1021 err=%b rdata=%h lat=%0d rd=%0d exp 0/%h/3/1", er, rd, lat, rc, exp_rd);
        end
        txn(1'b1, 24'hFFFFFE, 24'h55AA55, 0, lat, rd, er, rc, wc, sb, stb, ok);
        tests_run++;
        if (er !== 1'b1 || wc !== 0 || lat !== 1) begin
            tests_failed++; $display("FAIL range_wrap err=%b wr=%0d lat=%0d exp 1/0/1", er, wc, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat, rc, wc; logic [23:0] rd, a, exp_rd; logic er; bit sb, stb, ok;
        a = 24'($urandom_range(0, DEPTH - 3));
        exp_rd = model_rdata(1'b0, a);
        txn(1'b0, a, 24'h0, 5, lat, rd, er, rc, wc, sb, stb, ok);
        tests_run++;
        if (stb !== 0 || ok !== 1) begin
            tests_failed++; $display("FAIL backpressure stall_bad=%0d idle=%0d exp 0/1", stb, ok);
        end
        tests_run++;
        if (rd !== exp_rd || lat !== 3) begin
            tests_failed++; $display("FAIL backpressure_data rdata=%h lat=%0d exp %h/3", rd, lat, exp_rd);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 24'd100; resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_rd !== 1'b1) begin
            tests_failed++; $display("FAIL reset_mid_issue mem_rd=%b exp=1", mem_rd);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_state ready=%b valid=%b rd=%b wr=%b exp 1/0/0/0", req_ready, resp_valid, mem_rd, mem_wr);
        end
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_rd !== 1'b0) seen = 1;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("FAIL reset_mid_no_resp activity=%0d exp=0", seen);
        end
    endtask

    task automatic test_busy_changes();
        logic [23:0] a, b, got0, got1, exp0, exp1;
        logic [23:0] rd_addr [$];
        int n_resp, guard, wr_seen;
        bit ready_bad;
        a = 24'($urandom_range(0, 400));
        b = 24'($urandom_range(500, DEPTH - 3));
        exp0 = model_rdata(1'b0, a);
        exp1 = model_rdata(1'b0, b);
        n_resp = 0; guard = 0; wr_seen = 0; ready_bad = 0; got0 = '0; got1 = '0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a; resp_ready = 1'b1;
        @(posedge clk);
        while (n_resp < 2 && guard < 20) begin
            @(negedge clk);
            guard++;
            if (mem_rd === 1'b1) rd_addr.push_back(mem_address);
            if (mem_wr === 1'b1) wr_seen++;
            if (resp_valid === 1'b1) begin
                if (n_resp == 0) got0 = resp_rdata; else got1 = resp_rdata;
                n_resp++;
                req_addr = b; req_wr = 1'b0;
                if (n_resp == 2) req_valid = 1'b0;
            end else if (n_resp == 0) begin
                if (req_ready !== 1'b0) ready_bad = 1;
                req_addr = 24'($urandom_range(0, DEPTH - 3));
                req_wr = 1'($urandom);
            end
        end
        req_valid = 1'b0;
        tests_run++;
        if (n_resp !== 2 || got0 !== exp0 || got1 !== exp1) begin
            tests_failed++;
            $display("FAIL busy_resp n=%0d got=%h,%h exp 2 %h,%h", n_resp, got0, got1, exp0, exp1);
        end
        tests_run++;
        if (rd_addr.size() !== 2 || wr_seen !== 0 || ready_bad !== 0) begin
            tests_failed++;
            $display("FAIL busy_strobes rd=%0d wr=%0d ready_bad=%0d exp 2/0/0", rd_addr.size(), wr_seen, ready_bad);
        end else begin
            tests_run++;
            if (rd_addr[0] !== a || rd_addr[1] !== b) begin
                tests_failed++; $display("FAIL busy_addr got=%h,%h exp %h,%h", rd_addr[0], rd_addr[1], a, b);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, rc, wc, e_lat; logic [23:0] rd, a, d, e_rd; logic er, wr, e_err; bit sb, stb, ok;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: a = 24'd1021;
                1: a = 24'd1022;
                2: a = 24'd1023;
                3: a = 24'($urandom);
                default: a = 24'($urandom_range(0, DEPTH - 3));
            endcase
            wr = 1'($urandom);
            d  = 24'($urandom);
            e_rd  = model_rdata(wr, a);
            e_lat = model_lat(wr, a);
            e_err = !model_in_range(a);
            txn(wr, a, d, int'($urandom_range(0, 2)), lat, rd, er, rc, wc, sb, stb, ok);
            model_apply(wr, a, d);
            tests_run++;
            if (rd !== e_rd || er !== e_err || lat !== e_lat) begin
                tests_failed++;
                $display("FAIL rand_resp[%0d] wr=%b addr=%h rdata=%h err=%b lat=%0d exp %h/%b/%0d", i, wr, a, rd, er, lat, e_rd, e_err, e_lat);
            end
            tests_run++;
            if (rc !== int'(!wr && !e_err) || wc !== int'(wr && !e_err) || sb !== 0 || stb !== 0 || ok !== 1) begin
                tests_failed++;
                $display("FAIL rand_strobe[%0d] rd=%0d wr=%0d bad=%0d stall_bad=%0d idle=%0d", i, rc, wc, sb, stb, ok);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);
        test_reset();
        test_store_load();
        test_byte_order();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_busy_changes();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
